// File: rtl/drv_share_arbiter.sv
// Round-robin arbiter sharing one registered z/y/x output stage between N_REQ requesters.
// Define DRV_ARB_HOLD_LIMIT_EN to force a release after MAX_HOLD captured beats.
module drv_share_arbiter #(
    parameter int N_REQ    = 3,
    parameter int W        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_srst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_data,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [2:0]         o_owner,
    output logic [W-1:0]       o_data,
    output logic               o_valid
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam logic [3:0] HOLD_TOP = 4'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;

    logic [7:0]       req_pad;
    logic [3:0]       idx;
    logic [2:0]       win;
    logic             any_req;
    logic             own_req;
    logic             hold_last;
    logic [W-1:0]     own_data;

    // First active requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        req_pad = 8'(i_req);
        win     = ptr_q;
        any_req = 1'b0;
        idx     = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
            if (!any_req && req_pad[idx[2:0]]) begin
                any_req = 1'b1;
                win     = idx[2:0];
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == 3'(k)) begin
                own_req  = i_req[k];
                own_data = i_data[k*W +: W];
            end
        end
    end

`ifdef DRV_ARB_HOLD_LIMIT_EN
    assign hold_last = (hold_cnt_q == HOLD_TOP);
`else
    assign hold_last = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_srst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (any_req) state_d = BUSY;
                BUSY:    if (!own_req || hold_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Grant, capture and release; a dropped request wins over a forced release.
    always_comb begin
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        hold_cnt_d = hold_cnt_q;
        if (i_srst) begin
            gnt_d      = '0;
            owner_d    = '0;
            ptr_d      = '0;
            data_d     = '0;
            hold_cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (any_req) begin
                gnt_d = '0;
                for (int k = 0; k < N_REQ; k++) gnt_d[k] = (win == 3'(k));
                owner_d    = win;
                ptr_d      = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
                hold_cnt_d = '0;
            end
        end else if (own_req) begin
            data_d  = own_data;
            valid_d = 1'b1;
            if (hold_cnt_q < HOLD_TOP) hold_cnt_d = hold_cnt_q + 4'd1;
            if (hold_last) gnt_d = '0;
        end else begin
            gnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_owner = owner_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
endmodule

// File: tb/tb_drv_share_arbiter.sv
// Bench for drv_share_arbiter: directed scenarios plus randomized traffic against a beat-level model.
module tb_drv_share_arbiter;
    localparam int N  = 3;
    localparam int W  = 3;
    localparam int MH = 4;
    localparam int DW = N * W;
`ifdef DRV_ARB_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst, srst;
    logic [N-1:0]  req;
    logic [DW-1:0] data;
    logic [N-1:0]  gnt;
    logic [2:0]    owner;
    logic [W-1:0]  odata;
    logic          valid;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    drv_share_arbiter #(.N_REQ(N), .W(W), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_arst(arst), .i_srst(srst), .i_req(req), .i_data(data),
        .o_gnt(gnt), .o_owner(owner), .o_data(odata), .o_valid(valid)
    );

    // Model: who owns the stage, how many beats it has had, and where the next search starts.
    bit           m_busy;
    int           m_owner, m_next, m_beats;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_data;
    bit           m_valid;

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_next = 0; m_beats = 0;
        m_gnt = '0; m_data = '0; m_valid = 0;
    endfunction

    function automatic void model_step();
        int k;
        if (srst) begin
            model_reset();
            return;
        end
        m_valid = 0;
        if (!m_busy) begin
            for (int off = 0; off < N; off++) begin
                k = (m_next + off) % N;
                if (req[k]) begin
                    m_busy = 1; m_owner = k; m_beats = 0;
                    m_gnt = '0; m_gnt[k] = 1'b1;
                    m_next = (k + 1) % N;
                    break;
                end
            end
        end else if (req[m_owner]) begin
            m_data  = data[m_owner*W +: W];
            m_valid = 1;
            m_beats++;
            if (LIMIT && m_beats == MH) begin
                m_busy = 0; m_gnt = '0;
            end
        end else begin
            m_busy = 0; m_gnt = '0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        arst = 1'b0; srst = 1'b0; req = '0; data = '0;
        @(posedge clk);
        #1;
        arst = 1'b1;
    endtask

    task automatic test_reset();
        arst = 1'b0; srst = 1'b0; req = 3'b111; data = DW'($urandom);
        step(); step();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_cmp++; if (odata !== 3'b000) begin n_err++; $display("FAIL rst_data: got %b want 000", odata); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (owner !== 3'd0) begin n_err++; $display("FAIL rst_owner: got %0d want 0", owner); end
        #2 arst = 1'b1;
        step();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_first_valid: got %b want 0", valid); end
    endtask

    task automatic test_single();
        hard_reset();
        req = 3'b010; data = {3'b000, 3'b101, 3'b000};
        step();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b want 010", gnt); end
        n_cmp++; if (owner !== 3'd1) begin n_err++; $display("FAIL single_owner: got %0d want 1", owner); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_gnt_valid: got %b want 0", valid); end
        for (int b = 0; b < 3; b++) begin
            step();
            n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_beat%0d_valid: got %b want 1", b, valid); end
            n_cmp++; if (odata !== 3'b101) begin n_err++; $display("FAIL single_beat%0d_data: got %b want 101", b, odata); end
            n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL single_beat%0d_gnt: got %b want 010", b, gnt); end
        end
        req = 3'b000;
        step();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_rel_gnt: got %b want 000", gnt); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_rel_valid: got %b want 0", valid); end
        n_cmp++; if (odata !== 3'b101) begin n_err++; $display("FAIL single_rel_data: got %b want 101", odata); end
    endtask

    task automatic test_round_robin();
        int           order[4] = '{0, 1, 2, 0};
        logic [N-1:0] eg;
        hard_reset();
        req = 3'b111; data = {3'b011, 3'b010, 3'b001};
        for (int g = 0; g < 4; g++) begin
            eg = '0; eg[order[g]] = 1'b1;
            step();
            n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, eg); end
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rr_gap%0d_valid: got %b want 0", g, valid); end
            for (int b = 0; b < MH; b++) begin
                step();
                n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL rr_g%0d_b%0d_valid: got %b want 1", g, b, valid); end
                n_cmp++; if (odata !== W'(order[g] + 1)) begin n_err++; $display("FAIL rr_g%0d_b%0d_data: got %0d want %0d", g, b, odata, order[g] + 1); end
                n_cmp++; if (gnt !== ((b == MH - 1) ? 3'b000 : eg)) begin n_err++; $display("FAIL rr_g%0d_b%0d_gnt: got %b", g, b, gnt); end
            end
        end
        req = '0;
    endtask

    task automatic test_no_limit();
        hard_reset();
        req = 3'b011; data = {3'b000, 3'b011, 3'b110};
        step();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL nl_gnt: got %b want 001", gnt); end
        for (int c = 0; c < 19; c++) begin
            step();
            n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL nl_hold%0d_gnt: got %b want 001", c, gnt); end
            n_cmp++; if (valid !== 1'b1 || odata !== 3'b110) begin n_err++; $display("FAIL nl_hold%0d_beat: got v=%b d=%b want v=1 d=110", c, valid, odata); end
        end
        req = 3'b010;
        step();
        n_cmp++; if (gnt !== 3'b000 || valid !== 1'b0) begin n_err++; $display("FAIL nl_rel: got g=%b v=%b want g=000 v=0", gnt, valid); end
        step();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL nl_next_gnt: got %b want 010", gnt); end
        req = '0;
    endtask

    task automatic test_sync_reset();
        hard_reset();
        req = 3'b001; data = {3'b000, 3'b000, 3'b111};
        step(); step();
        n_cmp++; if (valid !== 1'b1 || odata !== 3'b111) begin n_err++; $display("FAIL srst_beat1: got v=%b d=%b want v=1 d=111", valid, odata); end
        srst = 1'b1;
        step();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL srst_gnt: got %b want 000", gnt); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL srst_valid: got %b want 0", valid); end
        n_cmp++; if (odata !== 3'b000) begin n_err++; $display("FAIL srst_data: got %b want 000", odata); end
        n_cmp++; if (owner !== 3'd0) begin n_err++; $display("FAIL srst_owner: got %0d want 0", owner); end
        srst = 1'b0; req = 3'b111;
        step();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL srst_next_gnt: got %b want 001", gnt); end
        req = '0;
    endtask

    task automatic test_async_reset();
        hard_reset();
        req = 3'b010; data = {3'b000, 3'b010, 3'b000};
        step(); step();
        n_cmp++; if (valid !== 1'b1 || odata !== 3'b010) begin n_err++; $display("FAIL arst_beat: got v=%b d=%b want v=1 d=010", valid, odata); end
        #2 arst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL arst_gnt: got %b want 000", gnt); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", valid); end
        n_cmp++; if (odata !== 3'b000) begin n_err++; $display("FAIL arst_data: got %b want 000", odata); end
        #1 arst = 1'b1;
        step();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL arst_no_capture: got %b want 0", valid); end
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL arst_regrant: got %b want 010", gnt); end
        req = '0;
    endtask

    task automatic test_random();
        hard_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
            data = DW'($urandom);
            srst = ($urandom_range(0, 60) == 0);
            @(posedge clk);
            model_step();
            #1;
            n_cmp++; if (gnt !== m_gnt) begin n_err++; $display("FAIL rnd%0d_gnt: got %b want %b", c, gnt, m_gnt); end
            n_cmp++; if (owner !== 3'(m_owner)) begin n_err++; $display("FAIL rnd%0d_owner: got %0d want %0d", c, owner, m_owner); end
            n_cmp++; if (valid !== m_valid) begin n_err++; $display("FAIL rnd%0d_valid: got %b want %b", c, valid, m_valid); end
            n_cmp++; if (odata !== m_data) begin n_err++; $display("FAIL rnd%0d_data: got %b want %b", c, odata, m_data); end
        end
        srst = 1'b0;
    endtask

    initial begin
        arst = 1'b0; srst = 1'b0; req = '0; data = '0;
        test_reset();
        test_single();
`ifdef DRV_ARB_HOLD_LIMIT_EN
        test_round_robin();
`else
        test_no_limit();
`endif
        test_sync_reset();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
